rr_arbiter8: RTL and testbench

//   8-requester round-robin arbiter for one shared resource. Search is a

---
 rtl/rr_arbiter8.sv | 157 +++++++++++++++
 tb/tb_rr_arbiter8.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered, held grants.
// Optional forced release after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    if ((MAX_HOLD < 2) || ((2 ** CNT_W) < MAX_HOLD)) begin : g_param_check
        $error("rr_arbiter8: MAX_HOLD must be in 2..2**CNT_W");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] r_id;
    logic [2:0] w_id_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       w_found;
    logic [2:0] w_win;
    logic [2:0] w_idx;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
`endif

    // Rotating priority search starting at the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = r_ptr;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_id;
        w_busy_nxt  = r_busy;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_gnt_nxt  = 8'd0;
                w_id_nxt   = 3'd0;
                w_busy_nxt = 1'b0;
                if (!en_n && w_found) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = 8'b1 << w_win;
                    w_id_nxt    = w_win;
                    w_busy_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = '0;
`endif
                end
            end
            BUSY: begin
                // Disable releases without charging the owner its turn.
                if (en_n) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = 8'd0;
                    w_id_nxt    = 3'd0;
                    w_busy_nxt  = 1'b0;
                end else if (!req[r_id]) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_id + 3'd1;
                    w_gnt_nxt   = 8'd0;
                    w_id_nxt    = 3'd0;
                    w_busy_nxt  = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (r_hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    w_state_nxt   = IDLE;
                    w_ptr_nxt     = r_id + 3'd1;
                    w_gnt_nxt     = 8'd0;
                    w_id_nxt      = 3'd0;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 8'd0;
                w_id_nxt    = 3'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_gnt   <= 8'd0;
            r_id    <= 3'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_id    <= w_id_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign gnt    = r_gnt;
    assign gnt_id = r_id;
    assign busy   = r_busy;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 against a cycle-level behavioural model.
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_rr_arbiter8;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned CNT_W    = 3;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Model state: owner index or -1, pointer, cycles granted so far, pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en_n   (en_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        g = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
        return {g, (m_owner < 0) ? 3'd0 : 3'(m_owner), (m_owner >= 0), m_tmo};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {gnt, gnt_id, busy, timeout};
    endfunction

    // Advance one clock edge, applying the arbitration rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_tmo = 1'b0;
        end else if (m_owner < 0) begin
            m_tmo = 1'b0;
            if (!en_n && req != 8'd0) begin
                for (int j = 0; j < 8; j++) begin
                    if (m_owner < 0 && req[(m_ptr + j) % 8]) m_owner = (m_ptr + j) % 8;
                end
                m_held = 1;
            end
        end else begin
            m_tmo = 1'b0;
            if (en_n) begin
                m_owner = -1;
            end else if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (TMO_EN && m_held == int'(MAX_HOLD)) begin
                m_ptr = (m_owner + 1) % 8;
                m_owner = -1;
                m_tmo = 1'b1;
            end else begin
                m_held++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en_n = 1'b0; req = 8'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_n = 1'b0; req = 8'hFF;
        tick(); tick();
        checks++;
        if (obs_vec() !== 13'd0) begin
            errors++; $display("FAIL reset: got %h expected 0000", obs_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_lsb_first();
        req = 8'h81;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL lsb_first: gnt=%h id=%0d busy=%b expected 01/0/1", gnt, gnt_id, busy);
        end
    endtask

    task automatic test_wrap();
        req = 8'h80;
        tick();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL wrap_dead: gnt=%h busy=%b expected 00/0", gnt, busy);
        end
        tick();
        checks++;
        if (gnt !== 8'h80 || gnt_id !== 3'd7) begin
            errors++; $display("FAIL wrap_grant7: gnt=%h id=%0d expected 80/7", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        req = 8'h03;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL wrap_ptr0: gnt=%h id=%0d expected 01/0", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] want;
        do_reset();
        req = 8'hFF;
        tick();
        for (int n = 0; n < 9; n++) begin
            want = 8'd1 << (n % 8);
            checks++;
            if (gnt !== want || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rr_order[%0d]: gnt=%h expected %h", n, gnt, want);
            end
            tick(); tick();
            req = 8'hFF & ~want;
            tick();
            checks++;
            if (gnt !== 8'h00 || busy !== 1'b0) begin
                errors++; $display("FAIL rr_dead[%0d]: gnt=%h busy=%b expected 00/0", n, gnt, busy);
            end
            req = 8'hFF;
            tick();
        end
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_enable();
        do_reset();
        req = 8'h02;
        tick();
        req = 8'h00;
        tick();
        req = 8'h06;
        tick();
        checks++;
        if (gnt !== 8'h04) begin
            errors++; $display("FAIL en_setup: gnt=%h expected 04", gnt);
        end
        en_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL en_release: gnt=%h busy=%b expected 00/0", gnt, busy);
        end
        tick(); tick();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL en_blocked: gnt=%h busy=%b expected 00/0", gnt, busy);
        end
        en_n = 1'b0;
        tick();
        checks++;
        if (gnt !== 8'h04 || gnt_id !== 3'd2 || timeout !== 1'b0) begin
            errors++; $display("FAIL en_ptr_kept: gnt=%h id=%0d expected 04/2", gnt, gnt_id);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h06;
        for (int c = 0; c < int'(MAX_HOLD); c++) begin
            tick();
            checks++;
            if (gnt !== 8'h02 || timeout !== 1'b0) begin
                errors++; $display("FAIL tmo_hold[%0d]: gnt=%h tmo=%b expected 02/0", c, gnt, timeout);
            end
        end
        tick();
        checks++;
`ifdef ARB_TIMEOUT_EN
        if (gnt !== 8'h00 || timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_fire: gnt=%h tmo=%b expected 00/1", gnt, timeout);
        end
`else
        if (gnt !== 8'h02 || timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_none: gnt=%h tmo=%b expected 02/0", gnt, timeout);
        end
`endif
        tick();
        checks++;
`ifdef ARB_TIMEOUT_EN
        if (gnt !== 8'h04 || timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_next: gnt=%h tmo=%b expected 04/0", gnt, timeout);
        end
`else
        if (gnt !== 8'h02 || timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_persist: gnt=%h tmo=%b expected 02/0", gnt, timeout);
        end
`endif
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_reset_midgrant();
        do_reset();
        req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        req = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10) begin
            errors++; $display("FAIL rst_setup: gnt=%h expected 10", gnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== 13'd0) begin
            errors++; $display("FAIL rst_mid: got %h expected 0000", obs_vec());
        end
        rst = 1'b0;
        req = 8'h30;
        tick();
        checks++;
        if (gnt !== 8'h10 || gnt_id !== 3'd4) begin
            errors++; $display("FAIL rst_ptr0: gnt=%h id=%0d expected 10/4", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en_n = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            tick();
            checks++;
            if (obs_vec() !== exp_vec() || !$onehot0(gnt)) begin
                errors++;
                $display("FAIL random[%0d]: got gnt=%h id=%0d busy=%b tmo=%b expected vec %h",
                         c, gnt, gnt_id, busy, timeout, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; en_n = 1'b0; req = 8'd0;
        test_reset();
        test_lsb_first();
        test_wrap();
        test_round_robin();
        test_enable();
        test_timeout();
        test_reset_midgrant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
